// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The controller connects through the master modport, the datapath (or a
// bench standing in for it) through the slave modport.
//
// Memory handshake: the controller holds mem_read or mem_write high and
// keeps every other output stable for as long as it is waiting. The access
// completes on the rising edge where mem_ready is high. mem_ready is only
// looked at in FETCH, MEMRD and MEMWR, and mem_read and mem_write are never
// high together.
interface multicycle_control_if #(
  parameter int OPW = 6,
  parameter int FNW = 6
);
  // Fields from the instruction register and status from the datapath.
  logic [OPW-1:0] opcode;
  logic [FNW-1:0] funct;
  logic           zero;
  logic           mem_ready;

  // Control outputs to the datapath.
  logic           pc_en;
  logic           iord;
  logic           mem_read;
  logic           mem_write;
  logic           ir_write;
  logic           reg_write;
  logic           reg_dst;
  logic           mem_to_reg;
  logic           alu_src_a;
  logic [1:0]     alu_src_b;
  logic [1:0]     pc_source;
  logic [2:0]     operation;
  logic           illegal_op;
  logic [3:0]     state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, pc_source, operation,
           illegal_op, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst,
           mem_to_reg, alu_src_a, alu_src_b, pc_source, operation,
           illegal_op, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath. It handles lw, sw,
// R-type (add/sub/and/or/slt) and beq, one instruction at a time, and stalls
// memory accesses on mem_ready.
// Optional feature: define MC_CTRL_JUMP_EN to add the JUMP state for
// opcode 000010. When the macro is not defined, that opcode is decoded as
// illegal.
module multicycle_control #(
  parameter int OPW = 6,
  parameter int FNW = 6
) (
  input logic                 clk,
  input logic                 rst_n,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9
  } state_t;

  localparam logic [OPW-1:0] OPC_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OPC_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OPC_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OPC_BEQ   = OPW'(6'b000100);
`ifdef MC_CTRL_JUMP_EN
  localparam logic [OPW-1:0] OPC_J     = OPW'(6'b000010);
`endif

  localparam logic [FNW-1:0] FN_ADD = FNW'(6'h20);
  localparam logic [FNW-1:0] FN_SUB = FNW'(6'h22);
  localparam logic [FNW-1:0] FN_AND = FNW'(6'h24);
  localparam logic [FNW-1:0] FN_OR  = FNW'(6'h25);
  localparam logic [FNW-1:0] FN_SLT = FNW'(6'h2A);

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q;
  state_t state_d;

  // Opcode classes. They are only meaningful from DECODE onward.
  logic is_lw;
  logic is_sw;
  logic is_rtype;
  logic is_beq;
  logic opcode_ok;
`ifdef MC_CTRL_JUMP_EN
  logic is_j;
`endif

  // R-type funct decode.
  logic       funct_ok;
  logic [2:0] funct_op;

  assign is_lw    = (bus.opcode == OPC_LW);
  assign is_sw    = (bus.opcode == OPC_SW);
  assign is_rtype = (bus.opcode == OPC_RTYPE);
  assign is_beq   = (bus.opcode == OPC_BEQ);
`ifdef MC_CTRL_JUMP_EN
  assign is_j      = (bus.opcode == OPC_J);
  assign opcode_ok = is_lw | is_sw | is_rtype | is_beq | is_j;
`else
  assign opcode_ok = is_lw | is_sw | is_rtype | is_beq;
`endif

  // Map funct to an ALU operation. An unknown funct is flagged for EXEC to reject.
  always_comb begin
    funct_ok = 1'b1;
    funct_op = ALU_ADD;
    case (bus.funct)
      FN_ADD:  funct_op = ALU_ADD;
      FN_SUB:  funct_op = ALU_SUB;
      FN_AND:  funct_op = ALU_AND;
      FN_OR:   funct_op = ALU_OR;
      FN_SLT:  funct_op = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

  // State register. An asynchronous reset aborts any access in flight and lands in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: sequence each instruction class and stall on mem_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (bus.mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (is_lw || is_sw)   state_d = ST_MEMADR;
        else if (is_rtype)    state_d = ST_EXEC;
        else if (is_beq)      state_d = ST_BRANCH;
`ifdef MC_CTRL_JUMP_EN
        else if (is_j)        state_d = ST_JUMP;
`endif
        else                  state_d = ST_FETCH;
      end
      ST_MEMADR: begin
        state_d = is_sw ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        if (bus.mem_ready) state_d = ST_MEMWB;
      end
      ST_MEMWB: begin
        state_d = ST_FETCH;
      end
      ST_MEMWR: begin
        if (bus.mem_ready) state_d = ST_FETCH;
      end
      ST_EXEC: begin
        state_d = funct_ok ? ST_ALUWB : ST_FETCH;
      end
      ST_ALUWB: begin
        state_d = ST_FETCH;
      end
      ST_BRANCH: begin
        state_d = ST_FETCH;
      end
`ifdef MC_CTRL_JUMP_EN
      ST_JUMP: begin
        state_d = ST_FETCH;
      end
`endif
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Output decode. Outputs are Moore from the state. The only exceptions are
  // the PC/IR load qualifiers (mem_ready, zero) and the decode-driven
  // illegal_op and ALU operation.
  always_comb begin
    bus.pc_en      = 1'b0;
    bus.iord       = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.pc_source  = 2'b00;
    bus.operation  = 3'b000;
    bus.illegal_op = 1'b0;
    case (state_q)
      ST_FETCH: begin
        // PC + 4 is computed while the instruction is read. The PC and IR load only when memory answers.
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.operation = ALU_ADD;
        bus.ir_write  = bus.mem_ready;
        bus.pc_en     = bus.mem_ready;
      end
      ST_DECODE: begin
        // Compute the branch target speculatively into ALUOut.
        bus.alu_src_b  = 2'b11;
        bus.operation  = ALU_ADD;
        bus.illegal_op = ~opcode_ok;
      end
      ST_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.operation = ALU_ADD;
      end
      ST_MEMRD: begin
        bus.iord     = 1'b1;
        bus.mem_read = 1'b1;
      end
      ST_MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        bus.iord      = 1'b1;
        bus.mem_write = 1'b1;
      end
      ST_EXEC: begin
        bus.alu_src_a  = 1'b1;
        bus.operation  = funct_op;
        bus.illegal_op = ~funct_ok;
      end
      ST_ALUWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        // The compare is done by SUB. ALUOut still holds the target from DECODE.
        bus.alu_src_a = 1'b1;
        bus.operation = ALU_SUB;
        bus.pc_source = 2'b01;
        bus.pc_en     = bus.zero;
      end
`ifdef MC_CTRL_JUMP_EN
      ST_JUMP: begin
        bus.pc_source = 2'b10;
        bus.pc_en     = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control. Each instruction is described as a
// queue of {mem_ready, expected state} entries. Every cycle is checked
// against a small per-state model of the control outputs.
module tb_multicycle_control;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   ir_cnt, pc_cnt, rw_cnt, mw_cnt, ill_cnt;

  logic [4:0] exp_q[$];

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic opcode_legal(input logic [5:0] op);
`ifdef MC_CTRL_JUMP_EN
    return (op == 6'h23) || (op == 6'h2B) || (op == 6'h00) || (op == 6'h04) || (op == 6'h02);
`else
    return (op == 6'h23) || (op == 6'h2B) || (op == 6'h00) || (op == 6'h04);
`endif
  endfunction

  function automatic logic funct_legal(input logic [5:0] fn);
    return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h25) || (fn == 6'h2A);
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'h20:   return 3'b010;
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      default: return 3'b111;
    endcase
  endfunction

  task automatic clr();
    ir_cnt = 0; pc_cnt = 0; rw_cnt = 0; mw_cnt = 0; ill_cnt = 0;
  endtask

  task automatic push(input logic rdy, input logic [3:0] st);
    exp_q.push_back({rdy, st});
  endtask

  // Driver and checker. Drains exp_q one clock at a time. Inputs change just
  // after the falling edge and outputs are sampled 1 ns later.
  task automatic play(input string tag);
    logic [4:0] e;
    logic [3:0] st;
    logic       rdy;
    logic [1:0] sb, ps;
    logic [2:0] op;
    logic       pe, ill;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      st = e[3:0];
      rdy = e[4];
      bus.mem_ready = rdy;
      #1;
      sb  = (st == 4'd0) ? 2'b01 : (st == 4'd1) ? 2'b11 : (st == 4'd2) ? 2'b10 : 2'b00;
      ps  = (st == 4'd8) ? 2'b01 : (st == 4'd9) ? 2'b10 : 2'b00;
      pe  = (st == 4'd0) ? rdy : (st == 4'd8) ? bus.zero : (st == 4'd9);
      ill = ((st == 4'd1) && !opcode_legal(bus.opcode)) ||
            ((st == 4'd6) && !funct_legal(bus.funct));
      op  = (st <= 4'd2) ? 3'b010 : (st == 4'd8) ? 3'b110 :
            (st == 4'd6) ? funct_alu(bus.funct) : 3'b000;
      check({tag, "_state"},      bus.state,      st);
      check({tag, "_mem_read"},   bus.mem_read,   (st == 4'd0) || (st == 4'd3));
      check({tag, "_mem_write"},  bus.mem_write,  st == 4'd5);
      check({tag, "_iord"},       bus.iord,       (st == 4'd3) || (st == 4'd5));
      check({tag, "_ir_write"},   bus.ir_write,   (st == 4'd0) && rdy);
      check({tag, "_reg_write"},  bus.reg_write,  (st == 4'd4) || (st == 4'd7));
      check({tag, "_reg_dst"},    bus.reg_dst,    st == 4'd7);
      check({tag, "_mem_to_reg"}, bus.mem_to_reg, st == 4'd4);
      check({tag, "_alu_src_a"},  bus.alu_src_a,  (st == 4'd2) || (st == 4'd6) || (st == 4'd8));
      check({tag, "_alu_src_b"},  bus.alu_src_b,  sb);
      check({tag, "_pc_source"},  bus.pc_source,  ps);
      check({tag, "_pc_en"},      bus.pc_en,      pe);
      check({tag, "_illegal_op"}, bus.illegal_op, ill);
      if (!ill) check({tag, "_operation"}, bus.operation, op);
      ir_cnt  += int'(bus.ir_write);
      pc_cnt  += int'(bus.pc_en);
      rw_cnt  += int'(bus.reg_write);
      mw_cnt  += int'(bus.mem_write);
      ill_cnt += int'(bus.illegal_op);
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    logic [5:0] fn_tab [4];
    n_checks = 0;
    n_errors = 0;
    clr();
    rst_n = 1'b0;
    bus.opcode = 6'h00;
    bus.funct = 6'h00;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;

    // Reset state. FETCH decodes are visible while reset is held.
    @(negedge clk);
    #1;
    check("rst_state",     bus.state,     4'd0);
    check("rst_mem_read",  bus.mem_read,  1'b1);
    check("rst_alu_src_b", bus.alu_src_b, 2'b01);
    check("rst_operation", bus.operation, 3'b010);
    check("rst_pc_en",     bus.pc_en,     1'b0);
    check("rst_ir_write",  bus.ir_write,  1'b0);
    check("rst_reg_write", bus.reg_write, 1'b0);
    rst_n = 1'b1;

    // 1: lw interrupted by an asynchronous reset in MEMRD.
    bus.opcode = 6'h23;
    push(1'b1, 4'd0); push(1'b1, 4'd1); push(1'b0, 4'd2);
    play("t1");
    bus.mem_ready = 1'b0;
    #1;
    check("t1_in_memrd", bus.state, 4'd3);
    #1;
    rst_n = 1'b0;
    #1;
    check("t1_async_state",     bus.state,     4'd0);
    check("t1_async_mem_read",  bus.mem_read,  1'b1);
    check("t1_async_reg_write", bus.reg_write, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    clr();
    push(1'b0, 4'd0); push(1'b0, 4'd0); push(1'b0, 4'd0);
    play("t1_post");
    check("t1_no_reg_write", rw_cnt, 0);
    check("t1_no_mem_write", mw_cnt, 0);

    // 2: R-type SUB with no stalls.
    clr();
    bus.opcode = 6'h00;
    bus.funct = 6'h22;
    push(1'b1, 4'd0); push(1'b1, 4'd1); push(1'b1, 4'd6); push(1'b1, 4'd7); push(1'b0, 4'd0);
    play("t2_sub");
    check("t2_reg_write_cycles", rw_cnt, 1);

    // The remaining R-type functs, to cover the ALU operation table.
    fn_tab[0] = 6'h20; fn_tab[1] = 6'h24; fn_tab[2] = 6'h25; fn_tab[3] = 6'h2A;
    for (int i = 0; i < 4; i++) begin
      bus.funct = fn_tab[i];
      push(1'b1, 4'd0); push(1'b1, 4'd1); push(1'b1, 4'd6); push(1'b1, 4'd7); push(1'b0, 4'd0);
      play("t2_rtype");
    end

    // 3: lw with two stall cycles in FETCH and two in MEMRD, 9 cycles in total.
    clr();
    bus.opcode = 6'h23;
    push(1'b0, 4'd0); push(1'b0, 4'd0); push(1'b1, 4'd0); push(1'b1, 4'd1); push(1'b1, 4'd2);
    push(1'b0, 4'd3); push(1'b0, 4'd3); push(1'b1, 4'd3); push(1'b1, 4'd4); push(1'b0, 4'd0);
    play("t3_lw");
    check("t3_ir_write_pulses", ir_cnt, 1);
    check("t3_pc_en_pulses",    pc_cnt, 1);
    check("t3_reg_write",       rw_cnt, 1);

    // sw with one stall cycle in MEMWR. mem_write stays high across the stall.
    clr();
    bus.opcode = 6'h2B;
    push(1'b1, 4'd0); push(1'b1, 4'd1); push(1'b1, 4'd2); push(1'b0, 4'd5); push(1'b1, 4'd5);
    push(1'b0, 4'd0);
    play("sw");
    check("sw_mem_write_cycles", mw_cnt, 2);
    check("sw_no_reg_write",     rw_cnt, 0);

    // 4: beq, taken and not taken.
    clr();
    bus.opcode = 6'h04;
    bus.zero = 1'b1;
    push(1'b1, 4'd0); push(1'b1, 4'd1); push(1'b1, 4'd8); push(1'b0, 4'd0);
    play("t4_taken");
    check("t4_taken_pc_en", pc_cnt, 2);
    clr();
    bus.zero = 1'b0;
    push(1'b1, 4'd0); push(1'b1, 4'd1); push(1'b1, 4'd8); push(1'b0, 4'd0);
    play("t4_not_taken");
    check("t4_not_taken_pc_en", pc_cnt, 1);

    // 5: illegal opcode, then illegal funct.
    clr();
    bus.opcode = 6'h3F;
    push(1'b1, 4'd0); push(1'b1, 4'd1); push(1'b0, 4'd0);
    play("t5_opc");
    check("t5_opc_ill_pulses", ill_cnt, 1);
    check("t5_opc_reg_write",  rw_cnt,  0);
    check("t5_opc_mem_write",  mw_cnt,  0);
    clr();
    bus.opcode = 6'h00;
    bus.funct = 6'h00;
    push(1'b1, 4'd0); push(1'b1, 4'd1); push(1'b1, 4'd6); push(1'b0, 4'd0);
    play("t5_fn");
    check("t5_fn_ill_pulses", ill_cnt, 1);
    check("t5_fn_reg_write",  rw_cnt,  0);
    check("t5_fn_mem_write",  mw_cnt,  0);

    // 6: jump opcode
    clr();
    bus.opcode = 6'h02;
`ifdef MC_CTRL_JUMP_EN
    push(1'b1, 4'd0); push(1'b1, 4'd1); push(1'b1, 4'd9); push(1'b0, 4'd0);
    play("t6_jump");
    check("t6_jump_pc_en", pc_cnt, 2);
`else
    push(1'b1, 4'd0); push(1'b1, 4'd1); push(1'b0, 4'd0);
    play("t6_jump");
    check("t6_jump_illegal", ill_cnt, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
